// File: rtl/cnt_pkg.sv
// Shared definitions for counter and timer blocks: count mode and prescaler sizing.
package cnt_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Prescaler counter width: $clog2(prescale), never narrower than one bit.
  function automatic int presc_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles into step strobes: one step every PRESCALE enabled cycles.
module tick_prescaler
  import cnt_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic step
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_presc;
    assign unused_presc = ^{clk, rst, restart};
    assign step         = en;
  end else begin : g_div
    localparam int            PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
        cnt_d = '0;
      end else if (en) begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // A pending restart is resolved by the parent's clr/load priority, not here.
    assign step = en & (cnt_q == LAST);
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down modulo counter with clear, load, wrap/saturate bounds, prescaled enable,
// registered terminal-count pulse and sticky overflow flag.
module updown_counter_mod
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero,
  output logic             at_max,
  output logic             ovf
);

  if (MODULO < 2 || longint'(MODULO) > (longint'(1) << WIDTH)) begin : g_bad_modulo
    $error("updown_counter_mod: MODULO=%0d out of range for WIDTH=%0d", MODULO, WIDTH);
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_counter_mod: PRESCALE=%0d must be >= 1", PRESCALE);
  end

  localparam cnt_mode_e        MODE  = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             bound_evt;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .restart (clr | load),
    .step    (step)
  );

  assign zero      = (q_q == '0);
  assign at_max    = (q_q == MAX_V);
  assign bound_evt = step & (up_dn ? at_max : zero);

  // Explicit bound compares keep wrap correct when MODULO < 2**WIDTH.
  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step) begin
      tc_d = bound_evt;
      if (bound_evt) begin
        ovf_d = 1'b1;
      end
      if (up_dn) begin
        if (at_max) begin
          q_d = (MODE == CNT_SAT) ? q_q : '0;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (zero) begin
          q_d = (MODE == CNT_SAT) ? q_q : MAX_V;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench: four counter configurations share one stimulus bus; each check targets one.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       ovf_clr = 1'b0;

  logic [3:0] q_w    [4];
  logic       tc_w   [4];
  logic       zero_w [4];
  logic       max_w  [4];
  logic       ovf_w  [4];

  int total = 0;
  int bad   = 0;
  int mod_t [4] = '{16, 10, 10, 16};

  always #5 clk = ~clk;

  // 0: defaults  1: MODULO=10 wrap  2: MODULO=10 saturate  3: PRESCALE=4
  updown_counter_mod u_a (.clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .q(q_w[0]), .tc(tc_w[0]), .zero(zero_w[0]),
    .at_max(max_w[0]), .ovf(ovf_w[0]));
  updown_counter_mod #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(1)) u_b (.clk(clk),
    .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q_w[1]), .tc(tc_w[1]), .zero(zero_w[1]), .at_max(max_w[1]),
    .ovf(ovf_w[1]));
  updown_counter_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(1)) u_c (.clk(clk),
    .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q_w[2]), .tc(tc_w[2]), .zero(zero_w[2]), .at_max(max_w[2]),
    .ovf(ovf_w[2]));
  updown_counter_mod #(.WIDTH(4), .MODULO(16), .SATURATE(0), .PRESCALE(4)) u_d (.clk(clk),
    .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q_w[3]), .tc(tc_w[3]), .zero(zero_w[3]), .at_max(max_w[3]),
    .ovf(ovf_w[3]));

  typedef struct {
    logic       clr, ld, en, ud, oc;
    logic [3:0] lv;
    int         sel;
    logic [3:0] eq;
    logic       etc, eovf;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic c, input logic l, input logic e, input logic u, input logic o,
                     input logic [3:0] lv, input int s, input logic [3:0] eq, input logic etc,
                     input logic eovf);
    vec_t v;
    v.clr = c; v.ld = l; v.en = e; v.ud = u; v.oc = o; v.lv = lv;
    v.sel = s; v.eq = eq; v.etc = etc; v.eovf = eovf;
    vt.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dut(input string nm, input int s, input logic [3:0] eq, input logic etc,
                         input logic eovf);
    check({nm, "_q"}, q_w[s], eq);
    check({nm, "_tc"}, tc_w[s], etc);
    check({nm, "_ovf"}, ovf_w[s], eovf);
    check({nm, "_zero"}, zero_w[s], eq == 4'd0);
    check({nm, "_atmax"}, max_w[s], int'(eq) == mod_t[s] - 1);
  endtask

  initial begin
    //  clr ld en ud oc lv  dut  q   tc ovf
    // default counter counting down from reset
    add(0, 0, 1, 0, 0, 0,  0, 15, 1, 1);
    add(0, 0, 1, 0, 0, 0,  0, 14, 0, 1);
    add(0, 0, 1, 0, 0, 0,  0, 13, 0, 1);
    // MODULO=10 wrap up, then clamped load
    add(1, 0, 0, 1, 0, 0,  1,  0, 0, 0);
    add(0, 1, 0, 1, 0, 8,  1,  8, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1,  9, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1,  0, 1, 1);
    add(0, 0, 1, 1, 0, 0,  1,  1, 0, 1);
    add(0, 1, 0, 1, 0, 12, 1,  9, 0, 1);
    // MODULO=10 saturate at top, then one step down
    add(1, 0, 0, 1, 0, 0,  2,  0, 0, 0);
    add(0, 1, 0, 1, 0, 9,  2,  9, 0, 0);
    add(0, 0, 1, 1, 0, 0,  2,  9, 1, 1);
    add(0, 0, 1, 1, 0, 0,  2,  9, 1, 1);
    add(0, 0, 1, 1, 0, 0,  2,  9, 1, 1);
    add(0, 0, 1, 0, 0, 0,  2,  8, 0, 1);
    // priority: clr beats load/en; event beats ovf_clr; load ignores en
    add(1, 0, 0, 0, 0, 0,  0,  0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  0, 15, 1, 1);
    add(1, 1, 1, 0, 0, 5,  0,  0, 0, 0);
    add(0, 0, 1, 0, 1, 0,  0, 15, 1, 1);
    add(0, 0, 1, 1, 1, 0,  0,  0, 1, 1);
    add(0, 0, 0, 1, 1, 0,  0,  0, 0, 0);
    add(0, 1, 1, 1, 0, 7,  0,  7, 0, 0);

    // reset state, all configurations
    tick();
    tick();
    for (int s = 0; s < 4; s++) chk_dut($sformatf("rst%0d", s), s, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    up_dn = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      clr = vt[i].clr; load = vt[i].ld; en = vt[i].en; up_dn = vt[i].ud;
      ovf_clr = vt[i].oc; load_val = vt[i].lv;
      tick();
      chk_dut($sformatf("v%0d", i), vt[i].sel, vt[i].eq, vt[i].etc, vt[i].eovf);
    end
    clr = 1'b0; load = 1'b0; en = 1'b0; ovf_clr = 1'b0;

    // prescale by 4: steps land on the 4th and 8th enabled clocks
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_dut($sformatf("pre%0d", k), 3, (k >= 8) ? 4'd2 : (k >= 4) ? 4'd1 : 4'd0, 1'b0, 1'b0);
    end
    tick();
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("frz%0d_q", k), q_w[3], 4'd2);
    end
    en = 1'b1;
    tick();
    check("frz_resume1_q", q_w[3], 4'd2);
    tick();
    check("frz_resume2_q", q_w[3], 4'd3);
    tick();
    tick();
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    check("preld_q", q_w[3], 4'd5);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("preld%0d_q", k), q_w[3], (k == 4) ? 4'd6 : 4'd5);
    end
    en = 1'b0;

    // asynchronous reset between edges, then counting resumes
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    chk_dut("arst_pre", 0, 4'd15, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_dut("arst_now", 0, 4'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk_dut("arst_post1", 0, 4'd15, 1'b1, 1'b1);
    tick();
    chk_dut("arst_post2", 0, 4'd14, 1'b0, 1'b1);
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
